cbc_dechain: RTL and testbench
==============================

# cbc_dechain

CBC-mode chaining stage wrapped around the 128-bit AES decryptor datapath. It accepts ciphertext blocks from the host with a valid/ready handshake and issues them to the decryptor's ct port. It pairs each returned decryptor plaintext with the chaining value (IV or previous ciphertext) that was current when the block was issued, and XORs them. Results are buffered in an output FIFO with valid/ready. Issue is credit-limited because the decryptor's pt output has no backpressure.

## Interface
- DEPTH, 4: maximum blocks in flight plus buffered output (power of 2, ≥2).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- iv  in  [0:127]  initialisation vector.
- iv_vld  in  1  request to load iv.
- iv_rdy  out  1  iv accepted when iv_vld && iv_rdy.
- in_ct  in  [0:127]  host ciphertext.
- in_vld  in  1  in_ct valid.
- in_rdy  out  1  block accepted when in_vld && in_rdy.
- dec_ct  out  [0:127]  to decryptor ct; combinational copy of in_ct.
- dec_ct_vld  out  1  to decryptor ct_vld.
- dec_ct_rdy  in  1  from decryptor ct_rdy.
- dec_pt  in  [0:127]  from decryptor pt.
- dec_pt_vld  in  1  from decryptor pt_vld; single-cycle pulse per block, no backpressure.
- out_pt  out  [0:127]  recovered plaintext (head of output FIFO).
- out_vld  out  1  out_pt valid.
- out_rdy  in  1  consumer accepts when out_vld && out_rdy.
- err  out  1  sticky; dec_pt_vld received with no block in flight.

## Operation
- States: IDLE (no IV loaded) and RUN.
- Registers:
  - chain: 128-bit chaining value.
  - mask FIFO: DEPTH × 128; holds the chain value for each in-flight block.
  - out FIFO: DEPTH × 128.
  - mcnt, ocnt: occupancy of the two FIFOs.
- Pipeline empty when mcnt==0 && ocnt==0.
- iv_rdy = (state==IDLE) || (state==RUN && pipeline empty).
- On IV load (iv_vld && iv_rdy):
  - chain ← iv, state ← RUN.
  - in_rdy forced 0 that cycle.
- credit = (mcnt + ocnt) < DEPTH, using registered counts.
- dec_ct_vld = state==RUN && in_vld && credit && !(iv_vld && iv_rdy).
- in_rdy = dec_ct_vld-conditions-without-in_vld && dec_ct_rdy; the host handshake and the decryptor handshake coincide.
- Issue (in_vld && in_rdy):
  - push chain into mask FIFO.
  - chain ← in_ct.
- Return (dec_pt_vld):
  - if mcnt>0: pop mask head m, push dec_pt ^ m into out FIFO.
  - if mcnt==0: nothing pushed, err ← 1.
- Output: out_vld = ocnt>0; pop on out_vld && out_rdy.
- Simultaneous events in one cycle are all legal; counts update by net ±:
  - issue + return, return + output pop, push + pop on either FIFO.
- Overflow is impossible by construction: credit bounds mcnt+ocnt ≤ DEPTH.
- An IV load is only possible with an empty pipeline, so in-flight blocks always use the chain value current at their issue.

## Timing
- Reset values (rst==0 at edge):
  - state IDLE; mcnt=ocnt=0; chain=0; err=0.
  - out_vld=0, out_pt=0, dec_ct_vld=0, in_rdy=0, iv_rdy=1.
- in_rdy/dec_ct_vld are combinational from in_vld, iv_vld, dec_ct_rdy and registered state.
- Issue-to-decryptor latency: 0 cycles (pass-through).
- dec_pt_vld in cycle t → out_vld=1 with correct out_pt in cycle t+1, unless older entries precede it in the FIFO.
- Credit freed by an output pop in cycle t is usable in cycle t+1.
- Reset asserted mid-operation discards all FIFO contents and chain; the next cycle is the reset state.
- The decryptor must be reset together with this block.
- FIFO pointers wrap modulo DEPTH.

## Test plan
- Reset → out_vld=0, in_rdy=0, iv_rdy=1, err=0.
- Key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f, ct 7649abac8119b246cee98e9b12e9197d then 5086cb9b507219ee95db113a917678b2:
  - out_pt 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51, in order.
- Hold out_rdy=0 while streaming 6 blocks with DEPTH=4:
  - exactly 4 issued; in_rdy stays 0.
  - release out_rdy → remaining 2 issue; all 6 outputs correct and in order.
- iv_vld asserted while mcnt=1:
  - iv_rdy=0 until the pipeline drains; then load succeeds.
  - next block uses the new IV; the block in flight used the old chain.
- Spurious dec_pt_vld with mcnt=0 → err=1, ocnt unchanged; err remains 1 until reset.
- Assert rst for one cycle with 3 blocks in flight → all outputs return to reset values, state IDLE, no out_vld afterwards.

Source files
------------

// File: rtl/cbc_dechain.sv
// CBC chaining stage around an AES decryptor: issues ciphertext, XORs returned plaintext with its chain value.
// Latency: 0 cycles to the decryptor, 1 cycle from dec_pt_vld to out_vld.
// Backpressure: issue stalls on the decryptor's ct_rdy or when in-flight plus buffered blocks reach DEPTH.

module cbc_fifo #(
   parameter int W     = 128,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [0:W-1]             push_dat,
   input  logic                     pop,
   output logic [0:W-1]             head_dat,
   output logic [$clog2(DEPTH):0]   cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

   logic [0:W-1]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage is cleared on reset so the head reads zero in the reset state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            cnt <= cnt + CNT_ONE;
         end else if (pop && !push) begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

   assign head_dat = mem[rd_ptr];
endmodule

module cbc_dechain #(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [0:127]   iv,
   input  logic           iv_vld,
   output logic           iv_rdy,
   input  logic [0:127]   in_ct,
   input  logic           in_vld,
   output logic           in_rdy,
   output logic [0:127]   dec_ct,
   output logic           dec_ct_vld,
   input  logic           dec_ct_rdy,
   input  logic [0:127]   dec_pt,
   input  logic           dec_pt_vld,
   output logic [0:127]   out_pt,
   output logic           out_vld,
   input  logic           out_rdy,
   output logic           err
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [0:127]  chain;
   logic [0:127]  mask_head;
   logic [0:127]  out_head;
   logic [CW-1:0] mcnt;
   logic [CW-1:0] ocnt;
   logic [CW:0]   used;
   logic          pipe_empty;
   logic          iv_load;
   logic          credit;
   logic          issue_ok;
   logic          issue;
   logic          ret;
   logic          out_pop;

   assign pipe_empty = (mcnt == '0) && (ocnt == '0);
   assign iv_rdy     = (state == IDLE) || pipe_empty;
   assign iv_load    = iv_vld && iv_rdy;

   // Every block either in the decryptor or waiting in the out FIFO holds one credit.
   assign used       = {1'b0, mcnt} + {1'b0, ocnt};
   assign credit     = used < DEPTH_V;
   assign issue_ok   = (state == RUN) && credit && !iv_load;

   assign dec_ct     = in_ct;
   assign dec_ct_vld = issue_ok && in_vld;
   assign in_rdy     = issue_ok && dec_ct_rdy;
   assign issue      = in_vld && in_rdy;

   assign ret        = dec_pt_vld && (mcnt != '0);
   assign out_vld    = ocnt != '0;
   assign out_pop    = out_vld && out_rdy;
   assign out_pt     = out_head;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         chain <= '0;
         err   <= 1'b0;
      end else begin
         if (iv_load) begin
            chain <= iv;
            state <= RUN;
         end else if (issue) begin
            chain <= in_ct;
         end
         // A returned block with nothing outstanding means the decryptor is out of sync.
         if (dec_pt_vld && (mcnt == '0)) begin
            err <= 1'b1;
         end
      end
   end

   cbc_fifo #(.W(128), .DEPTH(DEPTH)) u_mask_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (issue),
      .push_dat (chain),
      .pop      (ret),
      .head_dat (mask_head),
      .cnt      (mcnt)
   );

   cbc_fifo #(.W(128), .DEPTH(DEPTH)) u_out_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (ret),
      .push_dat (dec_pt ^ mask_head),
      .pop      (out_pop),
      .head_dat (out_head),
      .cnt      (ocnt)
   );
endmodule

// File: tb/tb_cbc_dechain.sv
// Randomized bench for cbc_dechain: host, mock decryptor and CBC reference model driven from one cycle task.
module tb_cbc_dechain;
   localparam int DEPTH = 4;

   localparam logic [0:127] AES_IV = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] C1     = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam logic [0:127] C2     = 128'h5086cb9b507219ee95db113a917678b2;
   localparam logic [0:127] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [0:127] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [0:127] iv;
   logic         iv_vld, iv_rdy;
   logic [0:127] in_ct;
   logic         in_vld, in_rdy;
   logic [0:127] dec_ct;
   logic         dec_ct_vld, dec_ct_rdy;
   logic [0:127] dec_pt;
   logic         dec_pt_vld;
   logic [0:127] out_pt;
   logic         out_vld, out_rdy, err;

   cbc_dechain #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .iv(iv), .iv_vld(iv_vld), .iv_rdy(iv_rdy),
      .in_ct(in_ct), .in_vld(in_vld), .in_rdy(in_rdy),
      .dec_ct(dec_ct), .dec_ct_vld(dec_ct_vld), .dec_ct_rdy(dec_ct_rdy),
      .dec_pt(dec_pt), .dec_pt_vld(dec_pt_vld),
      .out_pt(out_pt), .out_vld(out_vld), .out_rdy(out_rdy), .err(err)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Stand-in for AES decryption: the two known ciphertexts return their true AES-128 block decryptions.
   function automatic logic [0:127] dec_fn(input logic [0:127] ct);
      if (ct == C1) return P1 ^ AES_IV;
      if (ct == C2) return P2 ^ C1;
      return {ct[64:127], ct[0:63]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
   endfunction

   function automatic logic [0:127] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   typedef struct {
      logic [0:127] pt;
      int           due;
   } dent_t;

   // Reference model: P_i = D(C_i) ^ C_{i-1}, with blocks counted as in-decryptor or buffered.
   bit           run_m;
   logic [0:127] chain_m;
   int           mcnt_m, ocnt_m;
   bit           err_m;
   logic [0:127] exp_q[$];
   logic [0:127] host_q[$];
   logic [0:127] got_q[$];
   dent_t        dq[$];
   int           cyc = 0;
   int           issued = 0;
   bit           hold_out, rand_out, rand_crdy, hold_dec, spur, gaps;
   bit           last_ivload, last_issue;

   task automatic tick();
      bit    e_ivr, e_ivl, e_ok;
      dent_t e;
      @(negedge clk);
      last_ivload = 1'b0;
      last_issue  = 1'b0;
      if (!rst) begin
         run_m = 1'b0; chain_m = '0; mcnt_m = 0; ocnt_m = 0; err_m = 1'b0;
         exp_q.delete(); dq.delete(); host_q.delete();
      end else begin
         e_ivr = !run_m || (mcnt_m + ocnt_m == 0);
         e_ivl = iv_vld && e_ivr;
         e_ok  = run_m && (mcnt_m + ocnt_m < DEPTH) && !e_ivl;
         check("iv_rdy", iv_rdy, e_ivr);
         check("in_rdy", in_rdy, e_ok && dec_ct_rdy);
         check("dec_ct_vld", dec_ct_vld, e_ok && in_vld);
         check("out_vld", out_vld, ocnt_m > 0);
         check("err", err, err_m);
         if (dec_ct_vld) check("dec_ct", dec_ct, in_ct);
         if (ocnt_m > 0 && out_rdy) begin
            check("out_pt", out_pt, exp_q.pop_front());
            got_q.push_back(out_pt);
            ocnt_m--;
         end
         if (dec_pt_vld) begin
            if (mcnt_m > 0) begin
               mcnt_m--;
               ocnt_m++;
            end else begin
               err_m = 1'b1;
            end
         end
         if (e_ivl) begin
            chain_m = iv;
            run_m = 1'b1;
            last_ivload = 1'b1;
         end
         if (in_vld && e_ok && dec_ct_rdy) begin
            exp_q.push_back(dec_fn(in_ct) ^ chain_m);
            e.pt  = dec_fn(in_ct);
            e.due = cyc + int'($urandom_range(1, 4));
            dq.push_back(e);
            chain_m = in_ct;
            mcnt_m++;
            issued++;
            last_issue = 1'b1;
            void'(host_q.pop_front());
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      dec_pt_vld = 1'b0;
      if (spur) begin
         dec_pt_vld = 1'b1;
         dec_pt = rnd128();
         spur = 1'b0;
      end else if (!hold_dec && dq.size() > 0 && dq[0].due <= cyc) begin
         dec_pt = dq[0].pt;
         dec_pt_vld = 1'b1;
         void'(dq.pop_front());
      end
      in_vld = (host_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      if (host_q.size() > 0) in_ct = host_q[0];
      dec_ct_rdy = rand_crdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_rdy = hold_out ? 1'b0 : (rand_out ? ($urandom_range(0, 2) != 0) : 1'b1);
   endtask

   task automatic load_iv(input logic [0:127] v);
      bit ok = 1'b0;
      iv = v;
      iv_vld = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (last_ivload) begin
            ok = 1'b1;
            break;
         end
      end
      iv_vld = 1'b0;
      check("iv_load_done", ok, 1'b1);
   endtask

   task automatic drain(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (host_q.size() == 0 && dq.size() == 0 && mcnt_m == 0 && ocnt_m == 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check(tag, ok, 1'b1);
   endtask

   task automatic wait_issued(input int n, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (issued >= n) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check(tag, ok, 1'b1);
   endtask

   initial begin
      int           base;
      logic [0:127] x, y, prev, niv;
      rst = 1'b0; iv = '0; iv_vld = 1'b0; in_ct = '0; in_vld = 1'b0;
      dec_ct_rdy = 1'b1; dec_pt = '0; dec_pt_vld = 1'b0; out_rdy = 1'b1;
      hold_out = 0; rand_out = 0; rand_crdy = 0; hold_dec = 0; spur = 0; gaps = 0;
      repeat (2) tick();
      rst = 1'b1;

      in_vld = 1'b1;
      in_ct = C1;
      #1;
      check("rst_out_vld", out_vld, 1'b0);
      check("rst_in_rdy", in_rdy, 1'b0);
      check("rst_dec_ct_vld", dec_ct_vld, 1'b0);
      check("rst_iv_rdy", iv_rdy, 1'b1);
      check("rst_err", err, 1'b0);
      check("rst_out_pt", out_pt, '0);
      tick();
      in_vld = 1'b0;

      // Known-answer CBC vectors.
      got_q.delete();
      load_iv(AES_IV);
      host_q.push_back(C1);
      host_q.push_back(C2);
      drain("aes_drain");
      check("aes_count", got_q.size(), 2);
      if (got_q.size() >= 2) begin
         check("aes_pt0", got_q[0], P1);
         check("aes_pt1", got_q[1], P2);
      end

      // Credit limit with the consumer stalled.
      got_q.delete();
      hold_out = 1'b1;
      base = issued;
      for (int i = 0; i < 6; i++) host_q.push_back(rnd128());
      repeat (30) tick();
      check("hold_issued", issued - base, DEPTH);
      #1;
      check("hold_in_rdy", in_rdy, 1'b0);
      hold_out = 1'b0;
      drain("hold_drain");
      check("hold_total", issued - base, 6);
      check("hold_outs", got_q.size(), 6);

      // IV request while a block is still inside the decryptor.
      got_q.delete();
      prev = chain_m;
      x = rnd128();
      y = rnd128();
      niv = rnd128();
      hold_dec = 1'b1;
      host_q.push_back(x);
      wait_issued(issued + 1, "iv_wait_issue");
      iv = niv;
      iv_vld = 1'b1;
      repeat (5) tick();
      check("iv_blocked", last_ivload, 1'b0);
      #1;
      check("iv_rdy_busy", iv_rdy, 1'b0);
      hold_dec = 1'b0;
      load_iv(niv);
      host_q.push_back(y);
      drain("iv_drain");
      check("iv_count", got_q.size(), 2);
      if (got_q.size() >= 2) begin
         check("iv_old_chain", got_q[0], dec_fn(x) ^ prev);
         check("iv_new_chain", got_q[1], dec_fn(y) ^ niv);
      end

      // Spurious return with nothing outstanding.
      spur = 1'b1;
      tick();
      tick();
      check("spur_err", err, 1'b1);
      check("spur_out_vld", out_vld, 1'b0);

      // Random traffic with gaps, decryptor stalls, consumer stalls and an IV reload.
      gaps = 1'b1; rand_crdy = 1'b1; rand_out = 1'b1;
      load_iv(rnd128());
      for (int i = 0; i < 40; i++) host_q.push_back(rnd128());
      drain("rand_drain0");
      load_iv(rnd128());
      for (int i = 0; i < 25; i++) host_q.push_back(rnd128());
      drain("rand_drain1");
      check("err_sticky", err, 1'b1);
      gaps = 1'b0; rand_crdy = 1'b0; rand_out = 1'b0;

      // Reset with three blocks in flight.
      hold_dec = 1'b1;
      base = issued;
      for (int i = 0; i < 3; i++) host_q.push_back(rnd128());
      wait_issued(base + 3, "rst_wait_issue");
      check("rst_mcnt_before", mcnt_m, 3);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      hold_dec = 1'b0;
      in_vld = 1'b1;
      #1;
      check("mid_rst_out_vld", out_vld, 1'b0);
      check("mid_rst_iv_rdy", iv_rdy, 1'b1);
      check("mid_rst_in_rdy", in_rdy, 1'b0);
      check("mid_rst_dec_ct_vld", dec_ct_vld, 1'b0);
      check("mid_rst_err", err, 1'b0);
      check("mid_rst_out_pt", out_pt, '0);
      in_vld = 1'b0;
      repeat (10) tick();
      check("post_rst_out_vld", out_vld, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
